// File: rtl/byte_serial_wide_adder.sv
// Byte-serial NBYTES-wide adder that time-multiplexes one external 8-bit adder, LSB byte first.
// Define OVERFLOW_DETECT_EN to register signed overflow on Ovf; otherwise Ovf is tied low.
module byte_serial_wide_adder #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   OpA,
    input  logic [8*NBYTES-1:0]   OpB,
    input  logic                  CinIn,
    output logic [7:0]            A,
    output logic [7:0]            B,
    output logic                  Cin,
    input  logic [7:0]            Sum,
    input  logic                  Cout,
    output logic [8*NBYTES-1:0]   Result,
    output logic                  CoutOut,
    output logic                  Ovf,
    output logic                  busy,
    output logic                  done
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    opa_q, opa_d;
    logic [W-1:0]    opb_q, opb_d;
    logic [W-1:0]    result_q, result_d;
    logic            cout_q, cout_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            last_s;

    assign last_s = (idx_q == LAST_IDX);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? ADD : IDLE;
            ADD:     state_d = last_s ? DONE : ADD;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Adder-side outputs: driven only from latched operands while adding
    always_comb begin
        A   = 8'h00;
        B   = 8'h00;
        Cin = 1'b0;
        if (state_q == ADD) begin
            A   = opa_q[{idx_q, 3'b000} +: 8];
            B   = opb_q[{idx_q, 3'b000} +: 8];
            Cin = carry_q;
        end else begin
            A   = 8'h00;
            B   = 8'h00;
            Cin = 1'b0;
        end
    end

    // Datapath next-state: operand capture, byte write-back, carry chaining
    always_comb begin
        idx_d    = idx_q;
        carry_d  = carry_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        cout_d   = cout_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    opa_d   = OpA;
                    opb_d   = OpB;
                    carry_d = CinIn;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            ADD: begin
                result_d[{idx_q, 3'b000} +: 8] = Sum;
                carry_d = Cout;
                if (last_s) begin
                    idx_d  = '0;
                    cout_d = Cout;
                    done_d = 1'b1;
                end else begin
                    idx_d  = idx_q + IW'(1);
                end
            end
            DONE:    busy_d = 1'b0;
            default: busy_d = 1'b0;
        endcase
    end

    // Datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= '0;
            carry_q  <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef OVERFLOW_DETECT_EN
    logic ovf_q, ovf_d;

    // Signed overflow captured alongside the final carry
    always_comb begin
        ovf_d = ovf_q;
        if ((state_q == ADD) && last_s) begin
            ovf_d = (opa_q[W-1] == opb_q[W-1]) && (Sum[7] != opa_q[W-1]);
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Overflow register
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign Ovf = ovf_q;
`else
    assign Ovf = 1'b0;
`endif

    assign Result  = result_q;
    assign CoutOut = cout_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_byte_serial_wide_adder.sv
// Self-checking bench for byte_serial_wide_adder: arithmetic reference model, per-cycle compare, directed and random ops.
module tb_byte_serial_wide_adder;
    localparam int NB = 4;
    localparam int W  = 8 * NB;
`ifdef OVERFLOW_DETECT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, start, cin_in;
    logic [W-1:0]  opa, opb;
    logic [7:0]    a_s, b_s, sum_s;
    logic          cin_s, cout_s;
    logic [W-1:0]  result_s;
    logic          coutout_s, ovf_s, busy_s, done_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // External 8-bit adder
    assign {cout_s, sum_s} = {1'b0, a_s} + {1'b0, b_s} + {8'h00, cin_s};

    byte_serial_wide_adder #(.NBYTES(NB)) dut (
        .clk(clk), .rst(rst), .start(start), .OpA(opa), .OpB(opb), .CinIn(cin_in),
        .A(a_s), .B(b_s), .Cin(cin_s), .Sum(sum_s), .Cout(cout_s),
        .Result(result_s), .CoutOut(coutout_s), .Ovf(ovf_s), .busy(busy_s), .done(done_s)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Carry entering byte p of a+b+c
    function automatic logic exp_carry(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c, input int p);
        logic [W:0] mask, s;
        mask = ({{W{1'b0}}, 1'b1} << (8 * p)) - 1'b1;
        s = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {{W{1'b0}}, c};
        return s[8 * p];
    endfunction

    // Reference model: phase = cycles since acceptance (-1 when idle)
    int            m_phase = -1;
    bit            m_valid = 1'b0;
    logic [W-1:0]  m_a, m_b, m_res;
    logic          m_c, m_cout, m_ovf;
    logic [W:0]    m_full;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = -1; m_res = '0; m_cout = 1'b0; m_ovf = 1'b0; m_valid = 1'b1;
        end else if (m_phase < 0) begin
            if (start) begin
                m_a = opa; m_b = opb; m_c = cin_in; m_phase = 0;
            end
        end else begin
            m_phase++;
            if (m_phase == NB) begin
                m_full = {1'b0, m_a} + {1'b0, m_b} + {{W{1'b0}}, m_c};
                m_res  = m_full[W-1:0];
                m_cout = m_full[W];
                m_ovf  = OVF_EN && (m_a[W-1] == m_b[W-1]) && (m_full[W-1] != m_a[W-1]);
            end else if (m_phase > NB) begin
                m_phase = -1;
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", busy_s, (m_phase >= 0) && (m_phase <= NB));
            chk("done", done_s, m_phase == NB);
            if (m_phase >= 0 && m_phase < NB) begin
                chk("A", a_s, m_a[8*m_phase +: 8]);
                chk("B", b_s, m_b[8*m_phase +: 8]);
                chk("Cin", cin_s, exp_carry(m_a, m_b, m_c, m_phase));
            end else begin
                chk("A_idle", a_s, 8'h00);
                chk("B_idle", b_s, 8'h00);
                chk("Cin_idle", cin_s, 1'b0);
            end
            if (m_phase < 0 || m_phase == NB) begin
                chk("Result", result_s, m_res);
                chk("CoutOut", coutout_s, m_cout);
                chk("Ovf", ovf_s, m_ovf);
            end
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          output int lat, output int busy_cnt, output int cin_cnt,
                          output logic [W-1:0] res, output logic co, output logic ov);
        @(posedge clk); #2;
        opa = a; opb = b; cin_in = c; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0; opa = $urandom; opb = $urandom; cin_in = 1'b1;
        lat = 0; busy_cnt = 0; cin_cnt = 0; res = '0; co = 1'b0; ov = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (busy_s) busy_cnt++;
            if (busy_s && !done_s && cin_s) cin_cnt++;
            if (done_s) begin
                lat = n; res = result_s; co = coutout_s; ov = ovf_s;
                break;
            end
        end
    endtask

    int            lat, bcnt, ccnt, dcnt;
    logic [W-1:0]  res, ra, rb;
    logic          co, ov, rc;
    logic [W:0]    full;
    int            done_t[$];

    initial begin
        rst = 1'b1; start = 1'b0; opa = '0; opb = '0; cin_in = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy_s, 1'b0);
        chk("rst_result", result_s, 32'h0);
        chk("rst_cout", coutout_s, 1'b0);

        run_op(32'h0000000F, 32'h00000001, 1'b0, lat, bcnt, ccnt, res, co, ov);
        chk("t1_latency", lat, 5);
        chk("t1_busy_cycles", bcnt, 5);
        chk("t1_result", res, 32'h00000010);
        chk("t1_cout", co, 1'b0);

        run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, lat, bcnt, ccnt, res, co, ov);
        chk("t2_result", res, 32'h00000000);
        chk("t2_cout", co, 1'b1);
        chk("t2_cin_chain", ccnt, 4);

        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, lat, bcnt, ccnt, res, co, ov);
        chk("t3_result", res, 32'h80000000);
        chk("t3_cout", co, 1'b0);
        chk("t3_ovf", ov, OVF_EN);

        run_op(32'hAAAAAAAA, 32'h55555555, 1'b1, lat, bcnt, ccnt, res, co, ov);
        chk("t4_result", res, 32'h00000000);
        chk("t4_cout", co, 1'b1);
        chk("t4_ovf", ov, 1'b0);

        // start held high with operands changing every cycle
        @(posedge clk); #2;
        start = 1'b1; opa = $urandom; opb = $urandom; cin_in = 1'($urandom_range(0, 1));
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (done_s) done_t.push_back(i);
            @(posedge clk); #2;
            opa = $urandom; opb = $urandom; cin_in = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
        repeat (8) @(posedge clk);
        chk("b2b_count", done_t.size() >= 3, 1'b1);
        for (int i = 1; i < done_t.size(); i++) chk("b2b_spacing", done_t[i] - done_t[i-1], 6);

        // reset during the second ADD cycle
        @(posedge clk); #2;
        opa = 32'h000000FF; opb = 32'h00000001; cin_in = 1'b0; start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", busy_s, 1'b0);
        chk("mid_rst_result", result_s, 32'h0);
        chk("mid_rst_A", a_s, 8'h00);
        chk("mid_rst_Cin", cin_s, 1'b0);
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done_s) dcnt++;
        end
        chk("mid_rst_no_done", dcnt, 0);
        run_op(32'h12345678, 32'h11111111, 1'b1, lat, bcnt, ccnt, res, co, ov);
        chk("post_rst_result", res, 32'h2345678A);
        chk("post_rst_cout", co, 1'b0);

        for (int it = 0; it < 1000; it++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
            full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            run_op(ra, rb, rc, lat, bcnt, ccnt, res, co, ov);
            chk("rand_sum", {co, res}, full);
            chk("rand_latency", lat, 5);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
